ram_arb: RTL and testbench
==========================

# ram_arb

Sequencer and arbiter for the single shared data/instruction RAM port. Accepts read requests from the instruction fetch unit (IFU) and read/write requests from the load/store unit (LSU) over valid/ready handshakes. Serialises them onto the RAM's read and write ports and returns one-cycle response pulses. It sits between the core stages and the memory model, replacing the direct, always-enabled LSU-to-RAM connection.

## Interface
- DATA_WIDTH, `DATA_WIDTH (64): RAM data width; mask width is DATA_WIDTH/8
- ADDR_WIDTH, `ADDR_WIDTH (32): RAM address width
- RD_LATENCY, 1: cycles from o_ram_rd_en high to i_ram_rd_data valid; legal 1..4

- i_clk  in  1  clock
- i_rst  in  1  **synchronous, active-high reset**
- i_ifu_req_valid  in  1  IFU read request
- o_ifu_req_ready  out  1  IFU request accepted this cycle when valid
- i_ifu_req_addr  in  ADDR_WIDTH  IFU read address
- o_ifu_resp_valid  out  1  one-cycle pulse, IFU read data valid
- o_ifu_resp_data  out  DATA_WIDTH  IFU read data
- i_lsu_req_valid  in  1  LSU request
- o_lsu_req_ready  out  1  LSU request accepted this cycle when valid
- i_lsu_req_wr_en  in  1  1 = write, 0 = read
- i_lsu_req_addr  in  ADDR_WIDTH  LSU address
- i_lsu_req_wr_data  in  DATA_WIDTH  write data
- i_lsu_req_wr_mask  in  DATA_WIDTH/8  byte write mask
- o_lsu_resp_valid  out  1  one-cycle pulse: read data valid, or write acknowledge
- o_lsu_resp_data  out  DATA_WIDTH  read data; 0 on write ack
- o_ram_rd_en, o_ram_rd_addr  out  1, ADDR_WIDTH  RAM read strobe and address
- i_ram_rd_data  in  DATA_WIDTH  RAM read data
- o_ram_wr_en, o_ram_wr_addr, o_ram_wr_data, o_ram_wr_mask  out  1, ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8  RAM write strobe, address, data and mask

## Operation
- States:
  - IDLE → ISSUE on handshake.
  - ISSUE → WAIT for a read; ISSUE → RESP for a write.
  - WAIT → RESP when the latency counter reaches RD_LATENCY.
  - RESP → IDLE unconditionally.
- Ready:
  - Asserted only in IDLE, and only to the granted requester.
  - Combinational from the two request valids plus the arbitration state; a requester's ready never depends on its own valid.
- On handshake, register:
  - owner (IFU/LSU)
  - wr_en (forced 0 for IFU)
  - addr, wr_data, wr_mask
- ISSUE, exactly one cycle:
  - Read: o_ram_rd_en=1, o_ram_rd_addr=registered addr.
  - Write: o_ram_wr_en=1, with addr/data/mask from registers.
- WAIT:
  - Counter counts 1..RD_LATENCY.
  - i_ram_rd_data is captured into the response register on the cycle the counter equals RD_LATENCY.
- RESP:
  - Assert the owner's resp_valid for exactly one cycle; the other requester's resp_valid stays 0.
  - No response backpressure: the requester must consume the pulse.
- Address and data pass through unmodified; no alignment checks. Byte extraction and sign extension remain in the LSU.
- Outside ISSUE, all RAM strobes are 0. Address/data/mask outputs are 0 when the strobe is 0.
- Arbitration applies only when both valids are high in IDLE; a single requester is always granted.

## Timing
- Handshake at cycle T:
  - Read: ISSUE at T+1, resp_valid at T+2+RD_LATENCY.
  - Write: ISSUE (wr_en) at T+1, ack at T+2.
- Next accept is possible at the earliest in the cycle after RESP.
  - Read throughput: one per RD_LATENCY+3 cycles.
  - Write throughput: one per 3 cycles.
- Reset values: state IDLE, counter 0, all outputs 0 (both readies 0 while i_rst is high), last-grant register = IFU.
- Reset mid-transaction: the transaction is dropped with no response. The first cycle after reset release is IDLE.
- Request inputs are ignored outside IDLE; a requester holds valid until it sees ready.

## Configuration
- RAM_ARB_RR_EN defined:
  - Round-robin on a tie: the requester not granted last wins.
  - Last-grant updates on every handshake; reset value IFU, so the LSU wins the first tie.
- Not defined:
  - Fixed priority, LSU always wins a tie. The last-grant register is absent.

## Test plan
- **Single read:** RD_LATENCY=2, mem[0x100]=0x1122334455667788; IFU valid addr 0x100 at T → o_ram_rd_en at T+1, o_ifu_resp_valid at T+4 with data 0x1122334455667788, o_lsu_resp_valid 0.
- **Single write:** LSU write addr 0x200, data 0xDEADBEEF, mask 0x0F → o_ram_wr_en=1 with those values at T+1 only, o_lsu_resp_valid at T+2 with data 0; a later LSU read of 0x200 returns 0xDEADBEEF in the low word.
- **Tie arbitration:** IFU and LSU valid continuously from reset release.
  - With RAM_ARB_RR_EN: grants alternate LSU, IFU, LSU, IFU.
  - Without it: all LSU grants precede any IFU grant until LSU valid drops.
- **Busy hold-off:** a second request is raised during WAIT → its ready stays 0 until the cycle after RESP, then it is accepted; the first response is unaffected.
- **Reset mid-read:** i_rst is pulsed during WAIT → no resp_valid ever for that read; all outputs 0 the cycle after the reset edge; a new read after release completes with correct data.
- **Latency sweep:** RD_LATENCY=1 and 4 → resp_valid lands at exactly T+3 and T+6 respectively.

Source files
------------

// File: rtl/ram_arb.sv
// ram_arb: serialises IFU reads and LSU reads/writes onto one RAM port.
// Ports: i_clk/i_rst, IFU req/resp, LSU req/resp, RAM rd/wr strobes.
// Option: RAM_ARB_RR_EN selects round-robin ties (default LSU wins).

`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module ram_arb #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_ifu_req_valid,
  output logic                    o_ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_ifu_req_addr,
  output logic                    o_ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   o_ifu_resp_data,
  input  logic                    i_lsu_req_valid,
  output logic                    o_lsu_req_ready,
  input  logic                    i_lsu_req_wr_en,
  input  logic [ADDR_WIDTH-1:0]   i_lsu_req_addr,
  input  logic [DATA_WIDTH-1:0]   i_lsu_req_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_lsu_req_wr_mask,
  output logic                    o_lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   o_lsu_resp_data,
  output logic                    o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0]   o_ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]   i_ram_rd_data,
  output logic                    o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0]   o_ram_wr_addr,
  output logic [DATA_WIDTH-1:0]   o_ram_wr_data,
  output logic [DATA_WIDTH/8-1:0] o_ram_wr_mask
);

  localparam int MW = DATA_WIDTH / 8;
  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                  own_lsu;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [MW-1:0]         mask_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [2:0]            cnt;

  logic idle;
  logic lsu_prio;
  logic hs_ifu;
  logic hs_lsu;
  logic hs;

`ifdef RAM_ARB_RR_EN
  logic last_lsu;
  assign lsu_prio = !last_lsu;
`else
  assign lsu_prio = 1'b1;
`endif

  // Each ready looks only at the other side's valid, so a requester
  // never sees its own valid folded back into its ready.
  assign idle = (state == IDLE) && !i_rst;
  assign o_lsu_req_ready = idle && (!i_ifu_req_valid || lsu_prio);
  assign o_ifu_req_ready = idle && (!i_lsu_req_valid || !lsu_prio);

  assign hs_lsu = i_lsu_req_valid && o_lsu_req_ready;
  assign hs_ifu = i_ifu_req_valid && o_ifu_req_ready;
  assign hs     = hs_lsu || hs_ifu;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      own_lsu <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
`ifdef RAM_ARB_RR_EN
      last_lsu <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (hs) begin
        own_lsu <= hs_lsu;
        wr_q    <= hs_lsu && i_lsu_req_wr_en;
        addr_q  <= hs_lsu ? i_lsu_req_addr : i_ifu_req_addr;
        wdata_q <= hs_lsu ? i_lsu_req_wr_data : '0;
        mask_q  <= hs_lsu ? i_lsu_req_wr_mask : '0;
`ifdef RAM_ARB_RR_EN
        last_lsu <= hs_lsu;
`endif
      end
      case (state)
        ISSUE: cnt <= 3'd1;
        WAIT: begin
          if (cnt == LAT) begin
            rdata_q <= i_ram_rd_data;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: cnt <= 3'd0;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hs) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        state_nxt = wr_q ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == LAT) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    o_ram_rd_en      = 1'b0;
    o_ram_rd_addr    = '0;
    o_ram_wr_en      = 1'b0;
    o_ram_wr_addr    = '0;
    o_ram_wr_data    = '0;
    o_ram_wr_mask    = '0;
    o_ifu_resp_valid = 1'b0;
    o_ifu_resp_data  = '0;
    o_lsu_resp_valid = 1'b0;
    o_lsu_resp_data  = '0;
    if (!i_rst) begin
      if (state == ISSUE) begin
        if (wr_q) begin
          o_ram_wr_en   = 1'b1;
          o_ram_wr_addr = addr_q;
          o_ram_wr_data = wdata_q;
          o_ram_wr_mask = mask_q;
        end else begin
          o_ram_rd_en   = 1'b1;
          o_ram_rd_addr = addr_q;
        end
      end
      if (state == RESP) begin
        if (own_lsu) begin
          o_lsu_resp_valid = 1'b1;
          o_lsu_resp_data  = wr_q ? '0 : rdata_q;
        end else begin
          o_ifu_resp_valid = 1'b1;
          o_ifu_resp_data  = rdata_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: directed + random stimulus for ram_arb against a
// transaction-level model; extra instances cover latencies 1 and 4.

module tb_ram_arb;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        fill = 1'b0;
  logic        ifu_v = 1'b0;
  logic [31:0] ifu_a = '0;
  logic        lsu_v = 1'b0;
  logic        lsu_we = 1'b0;
  logic [31:0] lsu_a = '0;
  logic [63:0] lsu_d = '0;
  logic [7:0]  lsu_m = '0;

  logic        ifu_rdy, lsu_rdy;
  logic        ifu_rv, lsu_rv;
  logic [63:0] ifu_rd, lsu_rd;
  logic        rd_en, wr_en;
  logic [31:0] rd_addr, wr_addr;
  logic [63:0] wr_data, ram_rd_data;
  logic [7:0]  wr_mask;

  ram_arb #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .RD_LATENCY(LAT)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_ifu_req_valid(ifu_v), .o_ifu_req_ready(ifu_rdy),
    .i_ifu_req_addr(ifu_a),
    .o_ifu_resp_valid(ifu_rv), .o_ifu_resp_data(ifu_rd),
    .i_lsu_req_valid(lsu_v), .o_lsu_req_ready(lsu_rdy),
    .i_lsu_req_wr_en(lsu_we), .i_lsu_req_addr(lsu_a),
    .i_lsu_req_wr_data(lsu_d), .i_lsu_req_wr_mask(lsu_m),
    .o_lsu_resp_valid(lsu_rv), .o_lsu_resp_data(lsu_rd),
    .o_ram_rd_en(rd_en), .o_ram_rd_addr(rd_addr),
    .i_ram_rd_data(ram_rd_data),
    .o_ram_wr_en(wr_en), .o_ram_wr_addr(wr_addr),
    .o_ram_wr_data(wr_data), .o_ram_wr_mask(wr_mask)
  );

  function automatic logic [63:0] init_word(int i);
    if (i == 32) return 64'h1122_3344_5566_7788;
    return {32'(i) * 32'h9E37_79B9, ~32'(i)};
  endfunction

  // RAM behaviour: reads return data LAT cycles after the strobe,
  // junk otherwise; writes apply the byte mask.
  logic [63:0] ram [512];
  logic        pv [4];
  logic [31:0] pa [4];
  logic [63:0] junk;

  always_ff @(posedge clk) begin
    junk  <= {$urandom, $urandom};
    pv[0] <= rd_en;
    pa[0] <= rd_addr;
    for (int k = 1; k < 4; k++) begin
      pv[k] <= pv[k-1];
      pa[k] <= pa[k-1];
    end
    if (fill) begin
      for (int i = 0; i < 512; i++) ram[i] <= init_word(i);
    end else if (wr_en) begin
      for (int b = 0; b < 8; b++)
        if (wr_mask[b])
          ram[wr_addr[11:3]][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  assign ram_rd_data = pv[LAT-1] ? ram[pa[LAT-1][11:3]] : junk;

  // Latency-sweep instances: IFU only, data = f(address).
  logic             z1 = 1'b0;
  logic [31:0]      z32 = '0;
  logic [63:0]      z64 = '0;
  logic [7:0]       z8 = '0;
  logic [1:0]       x_iv = '0;
  logic [1:0][31:0] x_ia = '0;
  logic [1:0]       x_ir, x_rv, x_lr, x_lrv, x_rde, x_wre;
  logic [1:0][63:0] x_rd, x_lrd, x_wrd, x_rdat;
  logic [1:0][31:0] x_rda, x_wra;
  logic [1:0][7:0]  x_wrm;

  function automatic logic [63:0] xf(logic [31:0] a);
    return {a, ~a};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int XL = (g == 0) ? 1 : 4;
    logic        qv [4];
    logic [31:0] qa [4];
    always_ff @(posedge clk) begin
      qv[0] <= x_rde[g];
      qa[0] <= x_rda[g];
      for (int k = 1; k < 4; k++) begin
        qv[k] <= qv[k-1];
        qa[k] <= qa[k-1];
      end
    end
    assign x_rdat[g] = qv[XL-1] ? xf(qa[XL-1]) : 64'h0BAD_0BAD_0BAD_0BAD;
    ram_arb #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .RD_LATENCY(XL)) u_x (
      .i_clk(clk), .i_rst(rst),
      .i_ifu_req_valid(x_iv[g]), .o_ifu_req_ready(x_ir[g]),
      .i_ifu_req_addr(x_ia[g]),
      .o_ifu_resp_valid(x_rv[g]), .o_ifu_resp_data(x_rd[g]),
      .i_lsu_req_valid(z1), .o_lsu_req_ready(x_lr[g]),
      .i_lsu_req_wr_en(z1), .i_lsu_req_addr(z32),
      .i_lsu_req_wr_data(z64), .i_lsu_req_wr_mask(z8),
      .o_lsu_resp_valid(x_lrv[g]), .o_lsu_resp_data(x_lrd[g]),
      .o_ram_rd_en(x_rde[g]), .o_ram_rd_addr(x_rda[g]),
      .i_ram_rd_data(x_rdat[g]),
      .o_ram_wr_en(x_wre[g]), .o_ram_wr_addr(x_wra[g]),
      .o_ram_wr_data(x_wrd[g]), .o_ram_wr_mask(x_wrm[g])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference.
  logic [63:0] shadow [512];
  int          cyc = 0;
  bit          active = 0;
  int          t_iss = 0, t_resp = 0;
  bit          m_lsu, m_wr;
  logic [31:0] m_a;
  logic [63:0] m_d, m_rdata;
  logic [7:0]  m_m;
  bit          last_lsu = 0;
  bit          acc_i, acc_l;
  bit          rnd = 0, ifu_keep = 0, lsu_keep = 0;
  int          hs_i = -1, hs_l = -1, resp_i = -1, resp_l = -1;
  logic [63:0] dat_i, dat_l;
  bit          obs [$];
  int          x_hs [2], x_rc [2];
  logic [63:0] x_dat [2];

  task automatic accept(bit lsu);
    int idx;
    m_lsu = lsu;
    m_wr  = lsu && lsu_we;
    m_a   = lsu ? lsu_a : ifu_a;
    m_d   = lsu_d;
    m_m   = lsu_m;
    idx   = int'(m_a[11:3]);
    if (m_wr) begin
      for (int b = 0; b < 8; b++)
        if (m_m[b]) shadow[idx][8*b +: 8] = m_d[8*b +: 8];
      m_rdata = '0;
    end else begin
      m_rdata = shadow[idx];
    end
    active   = 1;
    t_iss    = cyc + 1;
    t_resp   = cyc + 2 + (m_wr ? 0 : LAT);
    last_lsu = lsu;
    if (lsu) acc_l = 1; else acc_i = 1;
  endtask

  task automatic model_check();
    bit idle, lp, iss, rsp;
    logic er_i, er_l, e_rde, e_wre, e_rvi, e_rvl;
    logic [31:0] e_rda, e_wra;
    logic [63:0] e_wrd, e_rdi, e_rdl;
    logic [7:0]  e_wrm;
    er_i = 0; er_l = 0; e_rde = 0; e_wre = 0; e_rvi = 0; e_rvl = 0;
    e_rda = '0; e_wra = '0; e_wrd = '0; e_rdi = '0; e_rdl = '0; e_wrm = '0;
    if (!rst) begin
      idle = !(active && cyc <= t_resp);
`ifdef RAM_ARB_RR_EN
      lp = !last_lsu;
`else
      lp = 1;
`endif
      er_l = idle && (!ifu_v || lp);
      er_i = idle && (!lsu_v || !lp);
      iss  = active && cyc == t_iss;
      rsp  = active && cyc == t_resp;
      if (iss && m_wr) begin
        e_wre = 1; e_wra = m_a; e_wrd = m_d; e_wrm = m_m;
      end
      if (iss && !m_wr) begin
        e_rde = 1; e_rda = m_a;
      end
      if (rsp && m_lsu) begin
        e_rvl = 1; e_rdl = m_rdata;
      end
      if (rsp && !m_lsu) begin
        e_rvi = 1; e_rdi = m_rdata;
      end
    end
    chk("ifu_ready", 64'(ifu_rdy), 64'(er_i));
    chk("lsu_ready", 64'(lsu_rdy), 64'(er_l));
    chk("rd_en", 64'(rd_en), 64'(e_rde));
    chk("rd_addr", 64'(rd_addr), 64'(e_rda));
    chk("wr_en", 64'(wr_en), 64'(e_wre));
    chk("wr_addr", 64'(wr_addr), 64'(e_wra));
    chk("wr_data", wr_data, e_wrd);
    chk("wr_mask", 64'(wr_mask), 64'(e_wrm));
    chk("ifu_resp_valid", 64'(ifu_rv), 64'(e_rvi));
    chk("ifu_resp_data", ifu_rd, e_rdi);
    chk("lsu_resp_valid", 64'(lsu_rv), 64'(e_rvl));
    chk("lsu_resp_data", lsu_rd, e_rdl);
    if (ifu_rv) begin resp_i = cyc; dat_i = ifu_rd; end
    if (lsu_rv) begin resp_l = cyc; dat_l = lsu_rd; end
    if (ifu_v && ifu_rdy) begin hs_i = cyc; obs.push_back(0); end
    if (lsu_v && lsu_rdy) begin hs_l = cyc; obs.push_back(1); end
    acc_i = 0;
    acc_l = 0;
    if (rst) begin
      active   = 0;
      last_lsu = 0;
    end else if (lsu_v && er_l) begin
      accept(1);
    end else if (ifu_v && er_i) begin
      accept(0);
    end
  endtask

  task automatic new_lsu();
    lsu_we = 1'($urandom);
    lsu_a  = $urandom;
    lsu_d  = {$urandom, $urandom};
    lsu_m  = 8'($urandom);
  endtask

  task automatic tick();
    bit xa [2];
    if (rnd) begin
      if (!ifu_v) begin
        ifu_a = $urandom;
        ifu_v = ($urandom_range(0, 2) == 0);
      end
      if (!lsu_v) begin
        new_lsu();
        lsu_v = ($urandom_range(0, 2) == 0);
      end
    end
    #1;
    model_check();
    for (int g = 0; g < 2; g++) begin
      xa[g] = x_iv[g] && x_ir[g];
      if (xa[g]) x_hs[g] = cyc;
      if (x_rv[g]) begin x_rc[g] = cyc; x_dat[g] = x_rd[g]; end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int g = 0; g < 2; g++) if (xa[g]) x_iv[g] = 1'b0;
    if (acc_i) begin
      if (ifu_keep) ifu_a = $urandom;
      else ifu_v = 1'b0;
    end
    if (acc_l) begin
      if (lsu_keep) new_lsu();
      else lsu_v = 1'b0;
    end
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 512; i++) shadow[i] = init_word(i);
    x_hs[0] = -1; x_hs[1] = -1; x_rc[0] = -1; x_rc[1] = -1;
    @(posedge clk);
    #1;
    // Reset with RAM fill.
    rst = 1; fill = 1;
    tick();
    fill = 0;
    tick();
    tick();
    rst = 0;

    // Single IFU read.
    ifu_v = 1; ifu_a = 32'h100;
    repeat (8) tick();
    chk("rd_latency", 64'(resp_i - hs_i), 64'(2 + LAT));
    chk("rd_data", dat_i, 64'h1122_3344_5566_7788);

    // Single LSU write, then read back.
    lsu_v = 1; lsu_we = 1; lsu_a = 32'h200;
    lsu_d = 64'hDEAD_BEEF; lsu_m = 8'h0F;
    repeat (5) tick();
    chk("wr_ack_latency", 64'(resp_l - hs_l), 64'd2);
    chk("wr_ack_data", dat_l, 64'd0);
    lsu_v = 1; lsu_we = 0; lsu_a = 32'h200;
    repeat (7) tick();
    chk("readback_lo", 64'(dat_l[31:0]), 64'hDEAD_BEEF);

    // Tie arbitration from reset release.
    rst = 1;
    ifu_v = 1; ifu_a = $urandom; ifu_keep = 1;
    lsu_v = 1; new_lsu(); lsu_keep = 1;
    tick();
    obs.delete();
    rst = 0;
    for (int n = 0; n < 40 && obs.size() < 4; n++) tick();
    chk("tie_grants", 64'(obs.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs.size()) begin
`ifdef RAM_ARB_RR_EN
        chk("tie_order", 64'(obs[i]), 64'((i % 2) == 0));
`else
        chk("tie_order", 64'(obs[i]), 64'd1);
`endif
      end
    end
    lsu_keep = 0; ifu_keep = 0;
    repeat (30) tick();
    found = 0;
    for (int i = 4; i < obs.size(); i++) if (!obs[i]) found = 1;
    chk("tie_ifu_served", 64'(found), 64'd1);

    // Busy hold-off: IFU raised during the LSU read's WAIT.
    hs_i = -1; resp_l = -1;
    lsu_v = 1; lsu_we = 0; lsu_a = $urandom;
    tick();
    tick();
    ifu_v = 1; ifu_a = $urandom;
    repeat (10) tick();
    chk("hold_lsu_latency", 64'(resp_l - hs_l), 64'(2 + LAT));
    chk("hold_ifu_accept", 64'(hs_i - resp_l), 64'd1);

    // Reset pulsed during WAIT drops the read.
    resp_i = -1;
    ifu_v = 1; ifu_a = 32'h0000_0108;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    repeat (8) tick();
    chk("rst_no_resp", 64'(resp_i), 64'(-1));
    ifu_v = 1; ifu_a = 32'h100;
    repeat (8) tick();
    chk("rst_new_rd_lat", 64'(resp_i - hs_i), 64'(2 + LAT));
    chk("rst_new_rd_data", dat_i, 64'h1122_3344_5566_7788);

    // Latency sweep on the extra instances.
    x_iv = 2'b11;
    x_ia[0] = $urandom;
    x_ia[1] = $urandom;
    repeat (12) tick();
    chk("lat1_cycles", 64'(x_rc[0] - x_hs[0]), 64'd3);
    chk("lat4_cycles", 64'(x_rc[1] - x_hs[1]), 64'd6);
    chk("lat1_data", x_dat[0], xf(x_ia[0]));
    chk("lat4_data", x_dat[1], xf(x_ia[1]));

    // Random traffic against the model.
    rnd = 1;
    repeat (2000) tick();
    rnd = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
